// File: rtl/life_common_pkg.sv
// -----------------------------------------------------------------------------
// life_common_pkg
// Board geometry and raster counter widths shared by the Game of Life blocks.
// The scheduler only needs the board edge (frame tick position) and the
// widths of the raster counters and the speed control.
// -----------------------------------------------------------------------------
package life_common_pkg;

  // Cells per board edge; the raster position (BOARD_SIZE, BOARD_SIZE) is the
  // first position past the visible board and marks the frame boundary.
  localparam int BOARD_SIZE    = 64;

  localparam int HCOUNT_WIDTH  = 11;
  localparam int VCOUNT_WIDTH  = 10;

  // Width of the per-frame speed increment.
  localparam int LOG_MAX_SPEED = 8;

endpackage

// File: rtl/life_pkg.sv
// -----------------------------------------------------------------------------
// life_pkg
// Scheduler-specific types and constants for life_sched.
//
// Build option: LIFE_SCHED_RANDOM_EN adds the FILL_RAND state to the
// scheduler state type.
// -----------------------------------------------------------------------------
package life_pkg;

  // Speed accumulator width and the level at which a generation is released.
  localparam int                    ACC_WIDTH     = 8;
  localparam logic [ACC_WIDTH-1:0]  COUNTER_THRES = 8'd60;

  // Random fill generator.
  localparam int                    LFSR_WIDTH    = 16;
  localparam logic [LFSR_WIDTH-1:0] LFSR_SEED     = 16'hACE1;

`ifdef LIFE_SCHED_RANDOM_EN
  typedef enum logic [1:0] {
    PAUSE     = 2'd0,
    RUN       = 2'd1,
    FILL_ZERO = 2'd2,
    FILL_RAND = 2'd3
  } sched_state_t;
`else
  typedef enum logic [1:0] {
    PAUSE     = 2'd0,
    RUN       = 2'd1,
    FILL_ZERO = 2'd2
  } sched_state_t;
`endif

endpackage

// File: rtl/life_lfsr.sv
// -----------------------------------------------------------------------------
// life_lfsr
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used as the cell source for random
// board fills. The register loads LFSR_SEED while reset is low and shifts once
// per clock while en is high.
//
// Build option: only present when LIFE_SCHED_RANDOM_EN is defined.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset (loads LFSR_SEED)
//   en        advance the sequence this cycle
//   rand_bit  current output bit (lfsr[0])
// -----------------------------------------------------------------------------
`ifdef LIFE_SCHED_RANDOM_EN
module life_lfsr
  import life_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic rand_bit
);

  logic [LFSR_WIDTH-1:0] lfsr_reg;
  logic                  feedback;

  // Tap positions 16,14,13,11 counted from 1 map to bits 15,13,12,10.
  assign feedback = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg <= LFSR_SEED;
    end else if (en) begin
      lfsr_reg <= {lfsr_reg[LFSR_WIDTH-2:0], feedback};
    end
  end

  assign rand_bit = lfsr_reg[0];

endmodule
`endif

// File: rtl/life_sched.sv
// -----------------------------------------------------------------------------
// life_sched
// Generation scheduler for the Game of Life datapath. Decides, once per video
// frame, whether the board evolves, is zero-filled, is randomly filled, or is
// left alone. A frame tick is the single cycle where the raster position is
// (BOARD_SIZE, BOARD_SIZE); every decision is registered on that tick and held
// for the whole following frame.
//
// Build option: LIFE_SCHED_RANDOM_EN compiles in random fill (LFSR, rand
// request latch and FILL_RAND). Without it rand_in is ignored.
//
// Ports:
//   clk_in         system clock, all state on the rising edge
//   rst_n_in       asynchronous active-low reset
//   hcount_in      raster x position
//   vcount_in      raster y position
//   speed_in       accumulator increment per frame while running
//   run_toggle_in  pulse: toggle PAUSE <-> RUN (ignored during fills)
//   step_in        pulse: one generation while paused
//   clear_in       pulse: zero-fill the board at the next frame tick
//   rand_in        pulse: random-fill the board at the next frame tick
//   update_out     evolve enable, held for one full frame
//   wr_en_out      board write enable (fill frames only)
//   alive_out      board write data
//   running_out    high in RUN
//   busy_out       fill pending or in progress
//   gen_count_out  generations evolved since reset (wraps)
// -----------------------------------------------------------------------------
module life_sched
  import life_common_pkg::*;
  import life_pkg::*;
(
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [HCOUNT_WIDTH-1:0]  hcount_in,
  input  logic [VCOUNT_WIDTH-1:0]  vcount_in,
  input  logic [LOG_MAX_SPEED-1:0] speed_in,
  input  logic                     run_toggle_in,
  input  logic                     step_in,
  input  logic                     clear_in,
  input  logic                     rand_in,
  output logic                     update_out,
  output logic                     wr_en_out,
  output logic                     alive_out,
  output logic                     running_out,
  output logic                     busy_out,
  output logic [15:0]              gen_count_out
);

  sched_state_t         state_reg, state_next;
  logic [ACC_WIDTH-1:0] acc_reg, acc_next;
  logic [15:0]          gen_reg, gen_next;
  logic                 update_reg, update_next;
  logic                 clear_pend_reg, clear_pend_next;
  logic                 step_pend_reg, step_pend_next;
  logic                 rand_pend_reg, rand_pend_next;

  logic                 frame_tick;
  logic                 fill_active;
  logic                 rand_fill;
  logic                 rand_bit;
  logic [ACC_WIDTH-1:0] speed_ext;

  assign frame_tick = (hcount_in == HCOUNT_WIDTH'(BOARD_SIZE)) &&
                      (vcount_in == VCOUNT_WIDTH'(BOARD_SIZE));

  assign speed_ext  = ACC_WIDTH'(speed_in);

`ifdef LIFE_SCHED_RANDOM_EN
  assign rand_fill   = (state_reg == FILL_RAND);
  assign fill_active = (state_reg == FILL_ZERO) || rand_fill;

  // The generator only runs while the random fill is writing the board, so
  // consecutive random fills continue the same sequence.
  life_lfsr u_lfsr (
    .clk      (clk_in),
    .rst_n    (rst_n_in),
    .en       (rand_fill),
    .rand_bit (rand_bit)
  );
`else
  logic unused_rand_in;
  assign unused_rand_in = rand_in;
  assign rand_fill      = 1'b0;
  assign rand_bit       = 1'b0;
  assign fill_active    = (state_reg == FILL_ZERO);
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg      <= PAUSE;
      acc_reg        <= '0;
      gen_reg        <= '0;
      update_reg     <= 1'b0;
      clear_pend_reg <= 1'b0;
      step_pend_reg  <= 1'b0;
      rand_pend_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      acc_reg        <= acc_next;
      gen_reg        <= gen_next;
      update_reg     <= update_next;
      clear_pend_reg <= clear_pend_next;
      step_pend_reg  <= step_pend_next;
      rand_pend_reg  <= rand_pend_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    acc_next        = acc_reg;
    gen_next        = gen_reg;
    update_next     = update_reg;
    // Requests are sticky; a pulse arriving on the tick itself is treated as
    // already pending so it is not lost.
    clear_pend_next = clear_pend_reg | clear_in;
    step_pend_next  = step_pend_reg | step_in;
`ifdef LIFE_SCHED_RANDOM_EN
    rand_pend_next  = rand_pend_reg | rand_in;
`else
    rand_pend_next  = 1'b0;
`endif

    if (frame_tick) begin
      // Fill requests abort whatever mode is active, including another fill.
      // Only the winning request is retired; lower-priority ones stay pending.
      if (clear_pend_next) begin
        state_next      = FILL_ZERO;
        clear_pend_next = 1'b0;
        update_next     = 1'b0;
      end
`ifdef LIFE_SCHED_RANDOM_EN
      else if (rand_pend_next) begin
        state_next     = FILL_RAND;
        rand_pend_next = 1'b0;
        update_next    = 1'b0;
      end
`endif
      else begin
        case (state_reg)
          RUN: begin
            if (acc_reg >= COUNTER_THRES) begin
              acc_next    = '0;
              update_next = 1'b1;
              gen_next    = gen_reg + 16'd1;
            end else begin
              acc_next    = acc_reg + speed_ext;
              update_next = 1'b0;
            end
          end
          PAUSE: begin
            if (step_pend_next) begin
              update_next    = 1'b1;
              gen_next       = gen_reg + 16'd1;
              step_pend_next = 1'b0;
            end else begin
              update_next    = 1'b0;
            end
          end
          default: begin
            // End of a fill frame: the board is fully written.
            state_next  = PAUSE;
            acc_next    = '0;
            update_next = 1'b0;
          end
        endcase
      end
    end

    // Run/pause toggles act immediately, but never override a fill entry or
    // exit decided above (state_next would already differ from state_reg).
    if (run_toggle_in && (state_next == state_reg)) begin
      if (state_reg == PAUSE) begin
        state_next = RUN;
      end else if (state_reg == RUN) begin
        state_next = PAUSE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Write enable is decoded straight from the state register so that an
  // asynchronous reset removes it without waiting for a clock edge.
  assign wr_en_out     = fill_active;
  assign alive_out     = rand_fill & rand_bit;
  assign update_out    = update_reg;
  assign running_out   = (state_reg == RUN);
  assign busy_out      = clear_pend_reg | rand_pend_reg | fill_active;
  assign gen_count_out = gen_reg;

endmodule
